// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the alu command sequencer: opcodes, FSM states, flag bit positions.
package alu_cmd_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam int FLAG_OF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_SF = 0;

    // Only the arithmetic opcodes produce meaningful alu flags.
    function automatic logic flags_meaningful(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Handshaked front-end for the 4-bit alu: registers a command, waits for the alu to settle,
// captures result and flags, and holds them on a valid/ready response port.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [2:0]       alu_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [4:0]       alu_out,
    input  logic             alu_of,
    input  logic             alu_zf,
    input  logic             alu_cf,
    input  logic             alu_sf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_out,
    output logic [3:0]       rsp_flags,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [4:0]       rsp_out_q, rsp_out_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_sel_d   = cmd_sel;
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    cnt_d       = SETTLE_LOAD;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                rsp_out_d   = alu_out;
                rsp_flags_d = 4'b0000;
                if (flags_meaningful(alu_sel_q)) begin
                    rsp_flags_d[FLAG_OF] = alu_of;
                    rsp_flags_d[FLAG_ZF] = alu_zf;
                    rsp_flags_d[FLAG_CF] = alu_cf;
                    rsp_flags_d[FLAG_SF] = alu_sf;
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset drops any in-flight command and reopens the command port at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cmd_ready_q <= 1'b1;
            alu_sel_q   <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= 5'd0;
            rsp_flags_q <= 4'd0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

endmodule
